pipeline_run_controller: RTL and testbench
==========================================

Name: pipeline_run_controller

Overview:
- Top-level sequencer for the five-stage MIPS pipeline.
- Gates PC, IF/DEC and downstream stage-register enables from three sources:
  - debug-unit run and step commands;
  - the load-use stall produced by the hazard unit;
  - branch flush and HALT detection from decode.
- On HALT it drains in-flight instructions, then freezes the pipeline and reports halted to the debug unit.

Parameters:
- PIPE_DRAIN, default 3: cycles needed for instructions older than HALT to retire (EX, MEM, WB).
- NB_DRAIN, default 2: width of the drain counter; must hold PIPE_DRAIN-1.
- NB_CYCLES, default 32: width of the executed-cycle counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- run_req_i  in  1  single-cycle pulse from debug unit: continuous execution.
- step_req_i  in  1  single-cycle pulse from debug unit: advance pipeline one cycle.
- halt_i  in  1  HALT opcode present in decode stage.
- load_use_stall_i  in  1  stall request from hazard unit.
- branch_taken_i  in  1  taken branch/jump resolved in decode.
- pc_write_o  out  1  PC register load enable.
- if_dec_write_o  out  1  IF/DEC register load enable.
- if_dec_flush_o  out  1  clear IF/DEC to NOP.
- dec_ex_bubble_o  out  1  load NOP/zero controls into DEC/EX.
- pipe_enable_o  out  1  enable for DEC/EX, EX/MEM, MEM/WB registers, register file and data-memory writes.
- halted_o  out  1  pipeline frozen after HALT drained.
- step_done_o  out  1  one-cycle pulse: a step completed.
- state_o  out  3  current state encoding (debug readback).
- cycle_count_o  out  NB_CYCLES  cycles with pipe_enable_o=1.

Behaviour:
- States and encodings: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. Other encodings go to IDLE on the next clock.
- Reset:
  - state=IDLE, drain counter=0, cycle_count=0, step_done_o=0.
  - All combinational outputs resolve to their IDLE values, i.e. all 0.
- Outputs are combinational from state and the current inputs, except step_done_o, which is registered.
- IDLE:
  - All enables, flush and bubble are 0.
  - run_req_i -> RUN. step_req_i -> STEP. Both asserted -> RUN.
- RUN and STEP share the "active" output equations:
  - pipe_enable_o=1.
  - stall = load_use_stall_i | halt_i.
  - pc_write_o = if_dec_write_o = ~stall.
  - dec_ex_bubble_o = load_use_stall_i.
  - if_dec_flush_o = branch_taken_i & ~load_use_stall_i & ~halt_i.
- Priority inside the active equations:
  - load_use_stall_i over halt_i: with both set, stay in the current state; HALT is re-evaluated next cycle.
  - halt_i over branch_taken_i.
  - load_use_stall_i over branch_taken_i: no flush; the branch is re-resolved after the stall.
- RUN transitions:
  - halt_i & ~load_use_stall_i -> DRAIN, loading drain counter = PIPE_DRAIN-1.
  - run_req_i and step_req_i are ignored.
- STEP:
  - Exactly one active cycle, then -> IDLE, with step_done_o=1 during the first IDLE cycle.
  - halt_i & ~load_use_stall_i during STEP -> DRAIN instead; step_done_o is not pulsed.
  - Requests arriving during STEP are ignored.
- DRAIN:
  - pc_write_o=0, if_dec_write_o=0, dec_ex_bubble_o=1, pipe_enable_o=1, if_dec_flush_o=0.
  - Counter decrements each cycle. When counter==0, -> HALTED on the next edge.
  - Total DRAIN dwell = PIPE_DRAIN cycles.
  - All inputs are ignored.
- HALTED:
  - All enables 0; halted_o=1.
  - Left only by reset; run/step requests are ignored.
- cycle_count:
  - Increments on every edge where pipe_enable_o=1.
  - Saturates at all-ones; no wrap.
- Reset asserted in any state, including mid-DRAIN: IDLE on the next edge, counters cleared.
- Latency:
  - A request in cycle n gives the state change at edge n+1; the first enabled cycle is n+1.
  - A step request in cycle n gives step_done_o high in cycle n+2.

Test Plan:
- Reset then idle: hold reset 2 cycles, release, no requests for 5 cycles -> all enables 0, state_o=0, cycle_count_o=0.
- Run/stall/flush:
  - run_req_i pulse at cycle 1 -> state_o=1 from cycle 2.
  - load_use_stall_i=1 with branch_taken_i=1 at cycle 4 -> pc_write_o=0, dec_ex_bubble_o=1, if_dec_flush_o=0.
  - Branch alone at cycle 5 -> if_dec_flush_o=1, pc_write_o=1.
- Single step:
  - step_req_i at cycle 1 -> cycle 2: pipe_enable_o=1, state_o=2.
  - cycle 3: state_o=0, step_done_o=1.
  - cycle_count_o=1.
  - Three steps -> cycle_count_o=3.
- HALT drain with PIPE_DRAIN=3:
  - In RUN, halt_i=1 at cycle 10 -> pc_write_o=0 at cycle 10.
  - DRAIN at cycles 11-13 with dec_ex_bubble_o=1 and pipe_enable_o=1.
  - halted_o=1, state_o=4, pipe_enable_o=0 from cycle 14.
  - run_req_i afterwards is ignored.
- HALT coincident with load-use:
  - halt_i=1 and load_use_stall_i=1 in cycle n -> remains in RUN.
  - load_use_stall_i=0 in cycle n+1 -> DRAIN at n+2.
- Reset mid-DRAIN: reset at the second DRAIN cycle -> IDLE next edge, counters 0, halted_o never asserted.

Source files
------------

// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer for the five-stage pipeline: gates PC, IF/DEC and
// downstream stage enables from debug commands, load-use stalls and HALT.
module pipeline_run_controller #(
  parameter int PIPE_DRAIN = 3,
  parameter int NB_DRAIN   = 2,
  parameter int NB_CYCLES  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run_req_i,
  input  logic                 step_req_i,
  input  logic                 halt_i,
  input  logic                 load_use_stall_i,
  input  logic                 branch_taken_i,
  output logic                 pc_write_o,
  output logic                 if_dec_write_o,
  output logic                 if_dec_flush_o,
  output logic                 dec_ex_bubble_o,
  output logic                 pipe_enable_o,
  output logic                 halted_o,
  output logic                 step_done_o,
  output logic [2:0]           state_o,
  output logic [NB_CYCLES-1:0] cycle_count_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [NB_DRAIN-1:0]   r_drain_cnt;
  logic [NB_CYCLES-1:0]  r_cycle_cnt;
  logic                  r_step_done;
  logic                  w_halt_go;

  // A stall coincident with HALT holds the current state; HALT is retried next cycle.
  assign w_halt_go = halt_i & ~load_use_stall_i;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: begin
        if (run_req_i)       w_next = RUN;
        else if (step_req_i) w_next = STEP;
        else                 w_next = IDLE;
      end
      RUN:    w_next = w_halt_go ? DRAIN : RUN;
      STEP: begin
        if (w_halt_go)   w_next = DRAIN;
        else if (halt_i) w_next = STEP;
        else             w_next = IDLE;
      end
      DRAIN:  w_next = (r_drain_cnt == '0) ? HALTED : DRAIN;
      HALTED: w_next = HALTED;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    pc_write_o      = 1'b0;
    if_dec_write_o  = 1'b0;
    if_dec_flush_o  = 1'b0;
    dec_ex_bubble_o = 1'b0;
    pipe_enable_o   = 1'b0;
    halted_o        = 1'b0;
    case (r_state)
      RUN, STEP: begin
        pipe_enable_o   = 1'b1;
        pc_write_o      = ~(load_use_stall_i | halt_i);
        if_dec_write_o  = ~(load_use_stall_i | halt_i);
        dec_ex_bubble_o = load_use_stall_i;
        if_dec_flush_o  = branch_taken_i & ~load_use_stall_i & ~halt_i;
      end
      DRAIN: begin
        pipe_enable_o   = 1'b1;
        dec_ex_bubble_o = 1'b1;
      end
      HALTED:  halted_o = 1'b1;
      default: ;
    endcase
  end

  // Counter holds the remaining DRAIN cycles after the current one.
  always_ff @(posedge clock) begin
    if (reset)
      r_drain_cnt <= '0;
    else if (r_state != DRAIN && w_next == DRAIN)
      r_drain_cnt <= NB_DRAIN'(PIPE_DRAIN - 1);
    else if (r_state == DRAIN && r_drain_cnt != '0)
      r_drain_cnt <= r_drain_cnt - NB_DRAIN'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_cycle_cnt <= '0;
    else if (pipe_enable_o && !(&r_cycle_cnt))
      r_cycle_cnt <= r_cycle_cnt + NB_CYCLES'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) r_step_done <= 1'b0;
    else       r_step_done <= (r_state == STEP) && (w_next == IDLE);
  end

  assign step_done_o   = r_step_done;
  assign state_o       = r_state;
  assign cycle_count_o = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench: directed test-plan steps followed by random traffic,
// all compared against a behavioural model of the run/step/halt rules.
module tb_pipeline_run_controller;

  localparam int PIPE_DRAIN = 3;

  logic clock = 1'b0;
  logic reset, run_req_i, step_req_i, halt_i, load_use_stall_i, branch_taken_i;
  logic pc_write_o, if_dec_write_o, if_dec_flush_o, dec_ex_bubble_o;
  logic pipe_enable_o, halted_o, step_done_o;
  logic [2:0]  state_o;
  logic [31:0] cycle_count_o;

  logic s_pcw, s_ifw, s_fl, s_bub, s_pe, s_hlt, s_sd;
  logic [2:0] s_state;
  logic [2:0] s_count;

  always #5 clock = ~clock;

  pipeline_run_controller #(.PIPE_DRAIN(PIPE_DRAIN), .NB_DRAIN(2), .NB_CYCLES(32)) dut (
    .clock(clock), .reset(reset), .run_req_i(run_req_i), .step_req_i(step_req_i),
    .halt_i(halt_i), .load_use_stall_i(load_use_stall_i), .branch_taken_i(branch_taken_i),
    .pc_write_o(pc_write_o), .if_dec_write_o(if_dec_write_o), .if_dec_flush_o(if_dec_flush_o),
    .dec_ex_bubble_o(dec_ex_bubble_o), .pipe_enable_o(pipe_enable_o), .halted_o(halted_o),
    .step_done_o(step_done_o), .state_o(state_o), .cycle_count_o(cycle_count_o)
  );

  // Narrow counter copy to exercise saturation.
  pipeline_run_controller #(.PIPE_DRAIN(PIPE_DRAIN), .NB_DRAIN(2), .NB_CYCLES(3)) u_sat (
    .clock(clock), .reset(reset), .run_req_i(run_req_i), .step_req_i(step_req_i),
    .halt_i(halt_i), .load_use_stall_i(load_use_stall_i), .branch_taken_i(branch_taken_i),
    .pc_write_o(s_pcw), .if_dec_write_o(s_ifw), .if_dec_flush_o(s_fl),
    .dec_ex_bubble_o(s_bub), .pipe_enable_o(s_pe), .halted_o(s_hlt),
    .step_done_o(s_sd), .state_o(s_state), .cycle_count_o(s_count)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: mode number (0 idle, 1 run, 2 step, 3 drain, 4 halted),
  // drain cycles still to spend, unbounded enabled-cycle tally.
  int m_mode = 0;
  int m_drain_left = 0;
  int m_count = 0;
  bit m_step_done = 0;
  bit m_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic compare_all();
    bit active, stall;
    bit e_pcw, e_fl, e_bub, e_pe, e_hlt;
    active = (m_mode == 1) || (m_mode == 2);
    stall  = load_use_stall_i || halt_i;
    e_pe   = active || (m_mode == 3);
    e_pcw  = active && !stall;
    e_bub  = (active && load_use_stall_i) || (m_mode == 3);
    e_fl   = active && branch_taken_i && !stall;
    e_hlt  = (m_mode == 4);
    chk("pc_write", 32'(pc_write_o), 32'(e_pcw));
    chk("if_dec_write", 32'(if_dec_write_o), 32'(e_pcw));
    chk("if_dec_flush", 32'(if_dec_flush_o), 32'(e_fl));
    chk("dec_ex_bubble", 32'(dec_ex_bubble_o), 32'(e_bub));
    chk("pipe_enable", 32'(pipe_enable_o), 32'(e_pe));
    chk("halted", 32'(halted_o), 32'(e_hlt));
    chk("step_done", 32'(step_done_o), 32'(m_step_done));
    chk("state", 32'(state_o), m_mode);
    chk("cycle_count", cycle_count_o, m_count);
    chk("sat_count", 32'(s_count), (m_count > 7) ? 7 : m_count);
  endtask

  task automatic model_edge();
    int nxt;
    bit enabled;
    enabled = (m_mode >= 1) && (m_mode <= 3);
    if (reset) begin
      m_mode = 0; m_drain_left = 0; m_count = 0; m_step_done = 0; m_valid = 1;
      return;
    end
    nxt = m_mode;
    case (m_mode)
      0: nxt = run_req_i ? 1 : (step_req_i ? 2 : 0);
      1: if (halt_i && !load_use_stall_i) nxt = 3;
      2: nxt = (halt_i && !load_use_stall_i) ? 3 : (halt_i ? 2 : 0);
      3: begin
        m_drain_left--;
        if (m_drain_left == 0) nxt = 4;
      end
      default: nxt = m_mode;
    endcase
    if (nxt == 3 && m_mode != 3) m_drain_left = PIPE_DRAIN;
    m_step_done = (m_mode == 2) && (nxt == 0);
    if (enabled) m_count++;
    m_mode = nxt;
  endtask

  task automatic tick(input logic rst, input logic r, input logic s,
                      input logic h, input logic l, input logic b);
    reset = rst; run_req_i = r; step_req_i = s;
    halt_i = h; load_use_stall_i = l; branch_taken_i = b;
    #3;
    if (m_valid) compare_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b1; run_req_i = 0; step_req_i = 0; halt_i = 0;
    load_use_stall_i = 0; branch_taken_i = 0;
    @(posedge clock); #1;

    // Reset then idle.
    tick(1,0,0,0,0,0); tick(1,0,0,0,0,0);
    repeat (5) tick(0,0,0,0,0,0);
    chk("idle_state", 32'(state_o), 0);
    chk("idle_count", cycle_count_o, 0);
    chk("idle_pe", 32'(pipe_enable_o), 0);

    // Run with stall+branch, then branch alone, then HALT drain.
    tick(0,1,0,0,0,0);
    chk("run_state", 32'(state_o), 1);
    tick(0,0,0,0,0,0);
    tick(0,0,0,0,1,1);
    tick(0,0,0,0,0,1);
    repeat (3) tick(0,0,0,0,0,0);
    tick(0,0,0,1,0,0);
    chk("drain_state", 32'(state_o), 3);
    tick(0,0,0,0,0,0); tick(0,0,0,0,0,0);
    chk("drain_last", 32'(state_o), 3);
    tick(0,0,0,0,0,0);
    chk("halted_state", 32'(state_o), 4);
    chk("halted_flag", 32'(halted_o), 1);
    tick(0,1,0,0,0,0); tick(0,0,1,0,0,0);
    chk("halted_sticky", 32'(state_o), 4);

    // Single steps.
    tick(1,0,0,0,0,0);
    tick(0,0,1,0,0,0);
    chk("step_state", 32'(state_o), 2);
    tick(0,0,0,0,0,0);
    chk("step_back_idle", 32'(state_o), 0);
    chk("step_done_pulse", 32'(step_done_o), 1);
    chk("step_count1", cycle_count_o, 1);
    tick(0,0,1,0,0,0); tick(0,0,0,0,0,0);
    tick(0,0,1,0,0,0); tick(0,0,0,0,0,0);
    chk("step_count3", cycle_count_o, 3);

    // HALT coincident with load-use.
    tick(0,1,0,0,0,0);
    tick(0,0,0,1,1,0);
    chk("coinc_run", 32'(state_o), 1);
    tick(0,0,0,1,0,0);
    chk("coinc_drain", 32'(state_o), 3);
    repeat (3) tick(0,0,0,0,0,0);
    chk("coinc_halted", 32'(state_o), 4);

    // Reset in the second DRAIN cycle.
    tick(1,0,0,0,0,0);
    tick(0,1,0,0,0,0);
    tick(0,0,0,1,0,0);
    tick(0,0,0,0,0,0);
    tick(1,0,0,0,0,0);
    chk("mid_drain_state", 32'(state_o), 0);
    chk("mid_drain_count", cycle_count_o, 0);
    chk("mid_drain_halted", 32'(halted_o), 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, s, h, l, b, rst;
      rst = ($urandom_range(0, 39) == 0);
      r   = ($urandom_range(0, 7) == 0);
      s   = ($urandom_range(0, 5) == 0);
      l   = ($urandom_range(0, 3) == 0);
      h   = !l && ($urandom_range(0, 15) == 0);
      b   = ($urandom_range(0, 2) == 0);
      tick(rst, r, s, h, l, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
